booth_issue: RTL and testbench

Operand-issue front end for the radix-2 Booth multiplier (control + data_path pair). Accepts signed operand pairs over a valid/ready interface and buffers them in a small FIFO. Issues one multiplication at a time by pulsing `mul_start` with operands held stable, then waits for `mul_done` and captures the 2W-bit product `{A,Q}`. Presents the product downstream on a valid/ready result port.

---
 rtl/booth_issue.sv | 174 +++++++++++++++++
 tb/tb_booth_issue.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_issue.sv
// booth_issue: operand-issue front end for a radix-2 Booth multiplier.
// Buffers signed operand pairs in a small FIFO and issues one multiplication
// at a time (start pulse, operands held stable). It then captures the 2W-bit
// {A,Q} product and offers it on a valid/ready result port.
// Optional feature macro: BOOTH_ZERO_BYPASS_EN. When it is defined, a head
// entry with a zero operand completes directly with a zero product and
// never starts the multiplier.
module booth_issue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   in_m,
    input  logic signed [WIDTH-1:0]   in_q,
    output logic                      mul_start,
    output logic signed [WIDTH-1:0]   mul_m,
    output logic signed [WIDTH-1:0]   mul_q,
    input  logic                      mul_done,
    input  logic signed [2*WIDTH-1:0] mul_prod,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] out_prod,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Operand storage (data only, never reset)
    logic signed [WIDTH-1:0] r_mem_m [DEPTH];
    logic signed [WIDTH-1:0] r_mem_q [DEPTH];

    // FIFO control
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Issue FSM and its registered outputs
    state_t                    r_state;
    logic                      r_mul_start;
    logic signed [WIDTH-1:0]   r_mul_m;
    logic signed [WIDTH-1:0]   r_mul_q;
    logic                      r_out_valid;
    logic signed [2*WIDTH-1:0] r_out_prod;
    logic                      r_busy;

    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_zero_head;
    logic signed [WIDTH-1:0]   w_head_m;
    logic signed [WIDTH-1:0]   w_head_q;

    // in_ready is a function of the occupancy only, never of in_valid
    assign in_ready   = (r_count != CNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push     = in_valid && in_ready;
    // Pop only when leaving IDLE with something queued
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_head_m   = r_mem_m[r_rd_ptr];
    assign w_head_q   = r_mem_q[r_rd_ptr];

`ifdef BOOTH_ZERO_BYPASS_EN
    assign w_zero_head = (w_head_m == '0) || (w_head_q == '0);
`else
    assign w_zero_head = 1'b0;
`endif

    assign mul_start  = r_mul_start;
    assign mul_m      = r_mul_m;
    assign mul_q      = r_mul_q;
    assign out_valid  = r_out_valid;
    assign out_prod   = r_out_prod;
    assign busy       = r_busy;
    assign fifo_count = r_count;

    // Write accepted operand pairs into the slot under the write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_m[r_wr_ptr] <= in_m;
            r_mem_q[r_wr_ptr] <= in_q;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop cancel out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Issue FSM: IDLE -> ISSUE -> WAIT -> DRAIN -> IDLE, one job in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_mul_start <= 1'b0;
            r_mul_m     <= '0;
            r_mul_q     <= '0;
            r_out_valid <= 1'b0;
            r_out_prod  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_busy <= 1'b1;
                        if (w_zero_head) begin
                            // Zero operand: product is known, skip the multiplier
                            r_out_prod  <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DRAIN;
                        end else begin
                            r_mul_m     <= w_head_m;
                            r_mul_q     <= w_head_q;
                            r_mul_start <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        r_out_prod  <= mul_prod;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_issue.sv
// Testbench for booth_issue: a behavioural multiplier answers each start
// pulse after a programmable latency. A queue of products, computed from
// the pushed operands with plain integer arithmetic, gives the expected
// results in push order.
`timescale 1ns/1ps
module tb_booth_issue;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [W-1:0]   in_m = '0;
    logic signed [W-1:0]   in_q = '0;
    logic                  mul_start;
    logic signed [W-1:0]   mul_m;
    logic signed [W-1:0]   mul_q;
    logic                  mul_done = 1'b0;
    logic signed [2*W-1:0] mul_prod = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic signed [2*W-1:0] out_prod;
    logic                  busy;
    logic [CW-1:0]         fifo_count;

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] exp_q [$];

    int mdl_lat  = 17;
    int mdl_cnt  = 0;
    int n_starts = 0;
    int n_dones  = 0;

    booth_issue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_m       (in_m),
        .in_q       (in_q),
        .mul_start  (mul_start),
        .mul_m      (mul_m),
        .mul_q      (mul_q),
        .mul_done   (mul_done),
        .mul_prod   (mul_prod),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_prod   (out_prod),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[2*W-1:0];
    endfunction

    // Multiplier model: has its own reset domain, so it ignores rst. It
    // multiplies whatever mul_m/mul_q hold when it finishes.
    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (mul_start) begin
            n_starts <= n_starts + 1;
            mdl_cnt  <= mdl_lat;
        end else if (mdl_cnt > 0) begin
            if (mdl_cnt == 1) begin
                mul_done <= 1'b1;
                mul_prod <= ref_mul(mul_m, mul_q);
                n_dones  <= n_dones + 1;
            end
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    task automatic push_one(input logic signed [W-1:0] m, input logic signed [W-1:0] q);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_m = m;
        in_q = q;
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(ref_mul(m, q));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic collect(input int n, input bit rnd);
        int got;
        int t;
        logic [2*W-1:0] e;
        got = 0;
        t = 0;
        while (got < n && t < 4000) begin
            @(negedge clk);
            t++;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL collect_extra: got %h required none", out_prod);
                end else begin
                    e = exp_q.pop_front();
                    if (out_prod !== e) begin
                        errors++;
                        $display("FAIL collect_order: got %h required %h", out_prod, e);
                    end
                end
                got++;
            end
        end
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL collect_timeout: got %0d products required %0d", got, n);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [70:0] v;
        #2;
        v = {in_ready, mul_start, mul_m, mul_q, out_valid, out_prod, busy, fifo_count};
        checks++;
        if (v !== {1'b1, 70'b0}) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", v, {1'b1, 70'b0});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fifo_count !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_idle: busy=%b count=%0d in_ready=%b required 0 0 1",
                     busy, fifo_count, in_ready);
        end
    endtask

    task automatic test_single();
        int s0;
        int t;
        mdl_lat = 17;
        out_ready = 1'b0;
        s0 = n_starts;
        push_one(16'sd3, 16'sd2);
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd1 || busy !== 1'b0 || mul_start !== 1'b0) begin
            errors++;
            $display("FAIL single_queued: count=%0d busy=%b start=%b required 1 0 0",
                     fifo_count, busy, mul_start);
        end
        @(negedge clk);
        checks++;
        if (mul_start !== 1'b1 || mul_m !== 16'sd3 || mul_q !== 16'sd2 ||
            fifo_count !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: start=%b m=%h q=%h count=%0d busy=%b required 1 0003 0002 0 1",
                     mul_start, mul_m, mul_q, fifo_count, busy);
        end
        t = 0;
        @(negedge clk);
        while (mul_done !== 1'b1 && t < 100) begin
            checks++;
            if (mul_start !== 1'b0 || mul_m !== 16'sd3 || mul_q !== 16'sd2 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_wait_hold: start=%b m=%h q=%h ov=%b required 0 0003 0002 0",
                         mul_start, mul_m, mul_q, out_valid);
            end
            @(negedge clk);
            t++;
        end
        checks++;
        if (mul_done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_done_cycle: done=%b ov=%b required 1 0", mul_done, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_prod !== 32'h0000_0006) begin
            errors++;
            $display("FAIL single_result: ov=%b prod=%h required 1 00000006", out_valid, out_prod);
        end
        checks++;
        if (n_starts - s0 !== 1) begin
            errors++;
            $display("FAIL single_start_count: got %0d required 1", n_starts - s0);
        end
        collect(1, 1'b0);
    endtask

    task automatic test_hold();
        int t;
        mdl_lat = 5;
        out_ready = 1'b0;
        push_one(-16'sd5, 16'sd7);
        t = 0;
        while (out_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_prod !== 32'hFFFF_FFDD) begin
            errors++;
            $display("FAIL hold_result: ov=%b prod=%h required 1 ffffffdd", out_valid, out_prod);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_prod !== 32'hFFFF_FFDD || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_stall: ov=%b prod=%h busy=%b required 1 ffffffdd 1",
                         out_valid, out_prod, busy);
            end
        end
        out_ready = 1'b1;
        void'(exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: ov=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [W-1:0] m6;
        logic signed [W-1:0] q6;
        mdl_lat = 3;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_one(W'($urandom), W'($urandom));
        end
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: count=%0d in_ready=%b required 4 0", fifo_count, in_ready);
        end
        m6 = W'($urandom);
        q6 = W'($urandom);
        in_valid = 1'b1;
        in_m = m6;
        in_q = q6;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_refuse: count=%0d in_ready=%b required 4 0", fifo_count, in_ready);
            end
        end
        in_valid = 1'b0;
        fork
            push_one(m6, q6);
            collect(6, 1'b1);
        join
    endtask

    task automatic test_push_pop();
        int t;
        logic [2*W-1:0] e;
        logic signed [W-1:0] m;
        logic signed [W-1:0] q;
        mdl_lat = 2;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_one(W'($urandom_range(1, 30000)), W'($urandom_range(1, 30000)));
        end
        t = 0;
        while (out_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (fifo_count !== 3'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pp_setup: count=%0d ov=%b required 2 1", fifo_count, out_valid);
        end
        e = exp_q.pop_front();
        checks++;
        if (out_prod !== e) begin
            errors++;
            $display("FAIL pp_first: got %h required %h", out_prod, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        m = W'($urandom);
        q = W'($urandom);
        in_valid = 1'b1;
        in_m = m;
        in_q = q;
        exp_q.push_back(ref_mul(m, q));
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd2 || mul_start !== 1'b1) begin
            errors++;
            $display("FAIL pp_simultaneous: count=%0d start=%b required 2 1", fifo_count, mul_start);
        end
        collect(3, 1'b1);
    endtask

    task automatic test_full_refuse();
        int t;
        logic [2*W-1:0] e;
        mdl_lat = 2;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_one(W'($urandom), W'($urandom));
        end
        t = 0;
        while (out_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_prod !== e) begin
            errors++;
            $display("FAIL fr_first: ov=%b got %h required %h", out_valid, out_prod, e);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_m = 16'sd11;
        in_q = 16'sd13;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fr_full_idle: count=%0d in_ready=%b required 4 0", fifo_count, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fr_pop_refuses_push: count=%0d in_ready=%b required 3 1", fifo_count, in_ready);
        end
        collect(4, 1'b1);
    endtask

    task automatic test_zero();
        logic signed [W-1:0] pm;
        logic signed [W-1:0] pq;
        int t;
        mdl_lat = 4;
        out_ready = 1'b0;
        pm = mul_m;
        pq = mul_q;
        push_one(16'sd0, 16'sd1234);
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL zero_queued: count=%0d required 1", fifo_count);
        end
        @(negedge clk);
`ifdef BOOTH_ZERO_BYPASS_EN
        checks++;
        if (out_valid !== 1'b1 || out_prod !== '0 || mul_start !== 1'b0 ||
            mul_m !== pm || mul_q !== pq || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_bypass: ov=%b prod=%h start=%b m=%h q=%h busy=%b required 1 0 0 %h %h 1",
                     out_valid, out_prod, mul_start, mul_m, mul_q, busy, pm, pq);
        end
`else
        checks++;
        if (mul_start !== 1'b1 || mul_m !== 16'sd0 || mul_q !== 16'sd1234 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_issue: start=%b m=%h q=%h ov=%b required 1 0000 04d2 0 (prev %h %h)",
                     mul_start, mul_m, mul_q, out_valid, pm, pq);
        end
        t = 0;
        while (out_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_prod !== '0) begin
            errors++;
            $display("FAIL zero_result: ov=%b prod=%h required 1 0", out_valid, out_prod);
        end
`endif
        collect(1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [70:0] v;
        int d0;
        mdl_lat = 30;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_one(W'($urandom_range(1, 500)), W'($urandom_range(1, 500)));
        end
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd3 || busy !== 1'b1 || mul_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_setup: count=%0d busy=%b start=%b required 3 1 0", fifo_count, busy, mul_start);
        end
        d0 = n_dones;
        #2;
        rst = 1'b0;
        #1;
        v = {in_ready, mul_start, mul_m, mul_q, out_valid, out_prod, busy, fifo_count};
        checks++;
        if (v !== {1'b1, 70'b0}) begin
            errors++;
            $display("FAIL rst_async: got %h required %h", v, {1'b1, 70'b0});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_stray_done: ov=%b busy=%b required 0 0", out_valid, busy);
            end
        end
        checks++;
        if (n_dones == d0) begin
            errors++;
            $display("FAIL rst_done_seen: got %0d done pulses required at least 1", n_dones - d0);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        mdl_lat = $urandom_range(1, 6);
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    logic signed [W-1:0] m;
                    logic signed [W-1:0] q;
                    m = W'($urandom);
                    q = W'($urandom);
                    if ($urandom_range(0, 5) == 0) m = '0;
                    if ($urandom_range(0, 7) == 0) q = {1'b1, {(W-1){1'b0}}};
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    push_one(m, q);
                end
            end
            collect(16, 1'b1);
        join
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_leftover: got %0d required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_back_to_back();
        test_push_pop();
        test_full_refuse();
        test_zero();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
